// File: rtl/program_loader.sv
// program_loader: streams big-endian bytes into instruction memory at boot, holding the CPU until the halt word lands or memory fills.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter logic [2:0] HALT_OPCODE = 3'b101
) (
  input  logic              _clock,
  input  logic              _reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [23:0] asm_q;
  logic accept, halt, last_slot;
  assign accept = in_valid && state == COLLECT;
  assign halt = mem_wdata[31:29] == HALT_OPCODE;
  // word_count doubles as the next write address; it is below capacity whenever WRITE is entered
  assign last_slot = word_count[ADDR_W-1:0] == '1;
  always_ff @(posedge _clock)
    if (_reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    in_ready = 1'b0;
    mem_we = 1'b0;
    cpu_hold = 1'b1;
    done = 1'b0;
    case (state)
      IDLE: state_n = start ? COLLECT : IDLE;
      COLLECT: begin
        in_ready = 1'b1;
        state_n = accept && cnt == 2'd3 ? WRITE : COLLECT;
      end
      WRITE: begin
        mem_we = 1'b1;
        state_n = halt || last_slot ? DONE : COLLECT;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done = 1'b1;
      end
    endcase
  end
  always_ff @(posedge _clock)
    if (_reset) begin
      cnt <= '0;
      asm_q <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      overflow <= 1'b0;
      word_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= '0;
        asm_q <= '0;
        overflow <= 1'b0;
        word_count <= '0;
      end
      if (accept) begin
        cnt <= cnt + 2'd1;
        asm_q <= {asm_q[15:0], in_data};
        if (cnt == 2'd3) begin
          mem_wdata <= {asm_q, in_data};
          mem_addr <= word_count[ADDR_W-1:0];
        end
      end
      if (state == WRITE) begin
        word_count <= word_count + 1'b1;
        overflow <= !halt && last_slot;
      end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives byte streams into 256-word and 4-word loaders and checks them against a word-level reference model.
module tb_program_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  always #5 clk = ~clk;
  logic a_in_ready, a_mem_we, a_cpu_hold, a_done, a_overflow;
  logic [7:0] a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0] a_word_count;
  logic b_in_ready, b_mem_we, b_cpu_hold, b_done, b_overflow;
  logic [1:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [2:0] b_word_count;
  program_loader #(.ADDR_W(8)) dut_a (
    ._clock(clk), ._reset(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .cpu_hold(a_cpu_hold), .done(a_done), .overflow(a_overflow), .word_count(a_word_count)
  );
  program_loader #(.ADDR_W(2)) dut_b (
    ._clock(clk), ._reset(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .cpu_hold(b_cpu_hold), .done(b_done), .overflow(b_overflow), .word_count(b_word_count)
  );
  int checks = 0, errors = 0;
  logic [31:0] a_w[$], b_w[$], exp_w[$];
  int a_a[$], b_a[$];
  int acc_a = 0, acc_b = 0;
  bit exp_ovf;
  logic [7:0] stim[$];
  // record every write cycle and every accepted byte, half a cycle away from the active edge
  always @(negedge clk) begin
    if (a_mem_we) begin
      a_w.push_back(a_mem_wdata);
      a_a.push_back(int'(a_mem_addr));
    end
    if (b_mem_we) begin
      b_w.push_back(b_mem_wdata);
      b_a.push_back(int'(b_mem_addr));
    end
    if (in_valid && a_in_ready) acc_a++;
    if (in_valid && b_in_ready) acc_b++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic add_word(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask
  function automatic logic [31:0] rnd_word(input bit halt);
    logic [31:0] w = $urandom;
    w[31:29] = halt ? 3'b101 : (w[31:29] == 3'b101 ? 3'b011 : w[31:29]);
    return w;
  endfunction
  // word-level reference: pack bytes big-endian, stop after a halt word or when capacity is reached
  task automatic model(input int cap);
    logic [31:0] w;
    exp_w.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i + 3 < stim.size(); i += 4) begin
      w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
      exp_w.push_back(w);
      if (w[31:29] == 3'b101) break;
      if (exp_w.size() == cap) begin
        exp_ovf = 1'b1;
        break;
      end
    end
  endtask
  task automatic send(input int first, input int last, input int gap, input bit sel);
    int g, t;
    for (int i = first; i <= last; i++) begin
      g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      in_valid = 1'b0;
      repeat (g) begin
        in_data = 8'($urandom);
        tick;
      end
      in_valid = 1'b1;
      in_data = stim[i];
      t = 0;
      while (!(sel ? b_in_ready : a_in_ready) && t < 50) begin
        tick;
        t++;
      end
      if (t >= 50) begin
        errors++;
        $display("FAIL send_timeout byte %0d: in_ready stayed 0, required 1", i);
      end
      tick;
    end
    in_valid = 1'b0;
  endtask
  task automatic run_load(input string name, input int gap, input bit sel);
    int bw, ba, n, t, wc, acc;
    logic d, h, o, r;
    model(sel ? 4 : 256);
    bw = sel ? b_w.size() : a_w.size();
    ba = sel ? acc_b : acc_a;
    do_start;
    send(0, 4 * exp_w.size() - 1, gap, sel);
    t = 0;
    while (!(sel ? b_done : a_done) && t < 100) begin
      tick;
      t++;
    end
    n = (sel ? b_w.size() : a_w.size()) - bw;
    d = sel ? b_done : a_done;
    h = sel ? b_cpu_hold : a_cpu_hold;
    o = sel ? b_overflow : a_overflow;
    r = sel ? b_in_ready : a_in_ready;
    wc = sel ? int'(b_word_count) : int'(a_word_count);
    acc = (sel ? acc_b : acc_a) - ba;
    checks++;
    if (n !== exp_w.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d write cycles, required %0d", name, n, exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < n; i++) begin
      checks++;
      if ((sel ? b_w[bw+i] : a_w[bw+i]) !== exp_w[i] || (sel ? b_a[bw+i] : a_a[bw+i]) != i) begin
        errors++;
        $display("FAIL %s write%0d: got %h @%0d, required %h @%0d", name, i,
                 sel ? b_w[bw+i] : a_w[bw+i], sel ? b_a[bw+i] : a_a[bw+i], exp_w[i], i);
      end
    end
    checks++;
    if (d !== 1'b1 || h !== 1'b0 || r !== 1'b0) begin
      errors++;
      $display("FAIL %s end_flags: done=%b cpu_hold=%b in_ready=%b, required 1 0 0", name, d, h, r);
    end
    checks++;
    if (o !== exp_ovf) begin
      errors++;
      $display("FAIL %s overflow: got %b, required %b", name, o, exp_ovf);
    end
    checks++;
    if (wc != exp_w.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d, required %0d", name, wc, exp_w.size());
    end
    checks++;
    if (acc != 4 * exp_w.size()) begin
      errors++;
      $display("FAIL %s accepted: got %0d bytes, required %0d", name, acc, 4 * exp_w.size());
    end
  endtask
  task automatic test_reset;
    do_reset;
    checks++;
    if (a_in_ready !== 1'b0 || a_mem_we !== 1'b0 || a_done !== 1'b0 || a_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b mem_we=%b done=%b overflow=%b, required 0 0 0 0",
               a_in_ready, a_mem_we, a_done, a_overflow);
    end
    checks++;
    if (a_cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL reset_cpu_hold: got %b, required 1", a_cpu_hold);
    end
    checks++;
    if (a_mem_addr !== 8'd0 || a_mem_wdata !== 32'd0 || a_word_count !== 9'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h wdata=%h word_count=%0d, required 0 0 0",
               a_mem_addr, a_mem_wdata, a_word_count);
    end
  endtask
  task automatic test_latency;
    do_reset;
    stim.delete();
    add_word(32'hA0000000);
    do_start;
    send(0, 3, 0, 1'b0);
    checks++;
    if (a_mem_we !== 1'b1 || a_done !== 1'b0 || a_cpu_hold !== 1'b1 || a_mem_addr !== 8'd0 || a_mem_wdata !== 32'hA0000000) begin
      errors++;
      $display("FAIL latency_write: mem_we=%b done=%b cpu_hold=%b addr=%h wdata=%h, required 1 0 1 00 a0000000",
               a_mem_we, a_done, a_cpu_hold, a_mem_addr, a_mem_wdata);
    end
    tick;
    checks++;
    if (a_mem_we !== 1'b0 || a_done !== 1'b1 || a_cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL latency_done: mem_we=%b done=%b cpu_hold=%b, required 0 1 0", a_mem_we, a_done, a_cpu_hold);
    end
  endtask
  task automatic test_basic;
    do_reset;
    stim.delete();
    add_word(32'h20000005);
    add_word(32'hA0000000);
    run_load("basic", 0, 1'b0);
  endtask
  task automatic test_gaps;
    do_reset;
    stim.delete();
    add_word(32'h20000005);
    add_word(32'hA0000000);
    run_load("gaps", 3, 1'b0);
  endtask
  task automatic test_overflow;
    do_reset;
    stim.delete();
    for (int i = 1; i <= 4; i++) add_word(32'(i));
    run_load("overflow", 0, 1'b1);
  endtask
  task automatic test_halt_last;
    do_reset;
    stim.delete();
    repeat (3) add_word(rnd_word(1'b0));
    add_word(32'hA0000000);
    run_load("halt_last", -1, 1'b1);
  endtask
  task automatic test_mid_reset;
    int bw;
    do_reset;
    stim.delete();
    add_word(rnd_word(1'b0));
    do_start;
    send(0, 1, 0, 1'b0);
    bw = a_w.size();
    do_reset;
    tick;
    checks++;
    if (a_w.size() != bw || a_in_ready !== 1'b0 || a_cpu_hold !== 1'b1 || a_done !== 1'b0 || a_word_count !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset_state: writes=%0d in_ready=%b cpu_hold=%b done=%b word_count=%0d, required %0d 0 1 0 0",
               a_w.size(), a_in_ready, a_cpu_hold, a_done, a_word_count, bw);
    end
    stim.delete();
    add_word(32'hA0000000);
    run_load("mid_reset_reload", 0, 1'b0);
  endtask
  task automatic test_ignored;
    int ba, bw;
    do_reset;
    ba = acc_a;
    in_valid = 1'b1;
    repeat (5) begin
      in_data = 8'($urandom);
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_a != ba || a_in_ready !== 1'b0 || a_cpu_hold !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: accepted=%0d in_ready=%b cpu_hold=%b done=%b, required 0 0 1 0",
               acc_a - ba, a_in_ready, a_cpu_hold, a_done);
    end
    stim.delete();
    add_word(32'hA1B2C3D4);
    bw = a_w.size();
    do_start;
    send(0, 1, 0, 1'b0);
    do_start;
    send(2, 3, 0, 1'b0);
    tick;
    checks++;
    if (a_done !== 1'b1 || a_w.size() != bw + 1 || (a_w.size() == bw + 1 ? a_w[bw] : 32'd0) !== 32'hA1B2C3D4) begin
      errors++;
      $display("FAIL start_in_collect: done=%b writes=%0d word=%h, required 1 1 a1b2c3d4",
               a_done, a_w.size() - bw, a_w.size() > bw ? a_w[bw] : 32'd0);
    end
    ba = acc_a;
    bw = a_w.size();
    start = 1'b1;
    in_valid = 1'b1;
    repeat (4) tick;
    start = 1'b0;
    in_valid = 1'b0;
    tick;
    checks++;
    if (a_done !== 1'b1 || a_in_ready !== 1'b0 || a_word_count !== 9'd1 || a_w.size() != bw || acc_a != ba) begin
      errors++;
      $display("FAIL done_ignore: done=%b in_ready=%b word_count=%0d writes=%0d accepted=%0d, required 1 0 1 0 0",
               a_done, a_in_ready, a_word_count, a_w.size() - bw, acc_a - ba);
    end
  endtask
  task automatic test_random;
    int n;
    repeat (4) begin
      do_reset;
      stim.delete();
      n = $urandom_range(0, 5);
      repeat (n) add_word(rnd_word(1'b0));
      add_word(rnd_word(1'b1));
      run_load("random_a", -1, 1'b0);
    end
    repeat (3) begin
      do_reset;
      stim.delete();
      n = $urandom_range(2, 6);
      repeat (n) add_word(rnd_word(1'b0));
      add_word(rnd_word(1'b1));
      run_load("random_b", -1, 1'b1);
    end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_basic;
    test_gaps;
    test_overflow;
    test_halt_last;
    test_mid_reset;
    test_ignored;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the calculator processor's instruction memory. Fetch only reads that memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive memory addresses starting at 0, holding the CPU (PC stalled) until the program is loaded.
- Loading ends after the halt (HCT) instruction is written, or when memory is full.

Parameters:
- ADDR_W, 8, instruction-memory address width; capacity 2^ADDR_W words.
- HALT_OPCODE, 3'b101, opcode value marking end of program (HCT).

Ports:
- _clock  input  1  system clock, all logic on rising edge.
- _reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load.
- in_data  input  8  incoming program byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  stalls PC/datapath while high.
- done  output  1  load complete.
- overflow  output  1  memory filled without a halt word.
- word_count  output  ADDR_W+1  number of words written.

Behaviour:
- One clock; reset is synchronous and active-high (_clock, _reset).
- Instruction word fields: opcode = [31:29], fonteA = [28:27], dest = [26:25], imediato = [24:0].
- Reset values:
  - state IDLE
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_hold=1, done=0, overflow=0, word_count=0
  - byte counter=0, assembly register=0
- A byte is transferred only when in_valid && in_ready on a rising edge. in_ready does not depend combinationally on in_valid.
- Byte order: first byte -> [31:24], second -> [23:16], third -> [15:8], fourth -> [7:0].
- States:
  - IDLE: in_ready=0. start=1 -> COLLECT, clearing byte counter, address, word_count and overflow. in_valid is ignored.
  - COLLECT: in_ready=1. Each accepted byte shifts into the assembly register and increments the 2-bit byte counter. The 4th accepted byte -> WRITE on the next edge. in_valid=0 stalls indefinitely with no timeout.
  - WRITE: exactly one cycle. in_ready=0, mem_we=1, mem_addr = current address, mem_wdata = assembled word. On exit, address+1 and word_count+1, then:
    - word[31:29]==HALT_OPCODE -> DONE;
    - else address was 2^ADDR_W-1 -> DONE with overflow=1;
    - else -> COLLECT.
  - DONE: cpu_hold=0, done=1, in_ready=0, mem_we=0. Terminal until _reset; start ignored.
- cpu_hold=1 in IDLE, COLLECT and WRITE. It falls in the first DONE cycle.
- Latency: 4th byte handshake on edge N -> mem_we high for cycle N..N+1 -> done/cpu_hold change visible after edge N+1.
- start while in COLLECT or WRITE: ignored; load continues.
- Halt word at the last address: DONE with overflow=0 (halt wins).
- mem_addr holds the last written address outside WRITE. mem_wdata holds the last word.
- _reset mid-operation: partial word discarded, return to IDLE with reset values. Words already written to memory are not erased.
- word_count saturates naturally at 2^ADDR_W (width ADDR_W+1); address never wraps past the last slot.

Test Plan:
- Reset, start, stream 20 00 00 05 A0 00 00 00 with in_valid held high -> write 0x20000005 @0, then 0xA0000000 @1; done=1, word_count=2, cpu_hold=0, overflow=0.
- Same stream with in_valid low for 3 cycles between every byte -> identical writes. No accept while in_valid=0. mem_we pulses exactly twice, one cycle each.
- ADDR_W=2, four words 0x00000001..0x00000004 -> writes @0..@3, overflow=1, done=1, word_count=4, in_ready=0 afterwards.
- ADDR_W=2, three non-halt words then 0xA0000000 -> fourth write @3, overflow=0, done=1.
- Start, accept 2 bytes, assert _reset one cycle -> IDLE, no mem_we, in_ready=0, cpu_hold=1. A new start plus a full halt word writes @0.
- in_valid with data in IDLE and in DONE -> in_ready=0, no state change. start pulse in COLLECT -> byte counter not cleared.
